// File: rtl/c1_pkg.sv
// rtl/c1_pkg.sv - C1 cache bus command codes, master FSM states and command helpers
package c1_pkg;

    localparam logic [2:0] C1_NOP          = 3'd0;
    localparam logic [2:0] C1_READ8        = 3'd1;
    localparam logic [2:0] C1_READ16       = 3'd2;
    localparam logic [2:0] C1_READ32       = 3'd3;
    localparam logic [2:0] C1_INV_LINE     = 3'd4;
    localparam logic [2:0] C1_WRITE8       = 3'd5;
    localparam logic [2:0] C1_WRITE16      = 3'd6;
    localparam logic [2:0] C1_WRITE32_RESP = 3'd7;

    typedef logic [2:0] c1_state_t;

    localparam c1_state_t ST_IDLE = 3'd0;
    localparam c1_state_t ST_A1   = 3'd1;
    localparam c1_state_t ST_A2   = 3'd2;
    localparam c1_state_t ST_TURN = 3'd3;
    localparam c1_state_t ST_WAIT = 3'd4;
    localparam c1_state_t ST_R2   = 3'd5;
    localparam c1_state_t ST_DONE = 3'd6;

    function automatic logic is_write(input logic [2:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32_RESP);
    endfunction

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
    endfunction

endpackage

// File: rtl/c1_master_if.sv
// rtl/c1_master_if.sv - request/response port of the C1 master
interface c1_master_if #(
    parameter int MEM_ADDR_SIZE = 19,
    parameter int BUS_SIZE      = 16
);
    logic                     req_valid;
    logic                     req_ready;
    logic [2:0]               req_cmd;
    logic [MEM_ADDR_SIZE-1:0] req_addr;
    logic [2*BUS_SIZE-1:0]    req_wdata;
    logic                     resp_valid;
    logic [2*BUS_SIZE-1:0]    resp_rdata;
    logic                     resp_err;

    modport master (
        input  req_valid, req_cmd, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        output req_valid, req_cmd, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/c1_tristate_drv.sv
// rtl/c1_tristate_drv.sv - enable-controlled driver onto a shared bidirectional bus
module c1_tristate_drv #(
    parameter int WIDTH = 16
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] out_i,
    inout  wire  [WIDTH-1:0] pad_io,
    output logic [WIDTH-1:0] in_o
);
    assign pad_io = en_i ? out_i : {WIDTH{1'bz}};
    assign in_o   = pad_io;
endmodule

// File: rtl/c1_master.sv
// rtl/c1_master.sv - CPU-side C1 cache bus requester with timeout
module c1_master
    import c1_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                                       clk,
    input  logic                                       reset,
    c1_master_if.master                                req,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                        data,
    inout  wire  [2:0]                                 command
);
    localparam int AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int DW = 2 * BUS_SIZE;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    c1_state_t              state_q, state_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic [BUS_SIZE-1:0]    lo_q, lo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   drive_cmd, drive_data;
    logic [AW-1:0]          addr_out;
    logic [BUS_SIZE-1:0]    data_out;
    logic [BUS_SIZE-1:0]    data_in;
    logic [2:0]             cmd_in;

    assign req.req_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign req.resp_valid = (state_q == ST_DONE);
    assign req.resp_rdata = rdata_q;
    assign req.resp_err   = err_q;
    assign accept         = req.req_valid && req.req_ready;

    // Drivers are gated by reset so the bus is released in the reset cycle itself.
    assign drive_cmd  = !reset && ((state_q == ST_A1) || (state_q == ST_A2));
    assign drive_data = !reset && (((state_q == ST_A1) && is_write(cmd_q)) ||
                                   ((state_q == ST_A2) && (cmd_q == C1_WRITE32_RESP)));
    assign addr_out   = (state_q == ST_A1) ? addr_q[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE]
                                           : AW'(addr_q[CACHE_OFFSET_SIZE-1:0]);
    assign data_out   = (state_q == ST_A1) ? wdata_q[BUS_SIZE-1:0] : wdata_q[DW-1:BUS_SIZE];
    assign address    = drive_cmd ? addr_out : {AW{1'bz}};

    c1_tristate_drv #(.WIDTH(3)) u_cmd_drv (
        .en_i(drive_cmd), .out_i(cmd_q), .pad_io(command), .in_o(cmd_in)
    );

    c1_tristate_drv #(.WIDTH(BUS_SIZE)) u_data_drv (
        .en_i(drive_data), .out_i(data_out), .pad_io(data), .in_o(data_in)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
                if (accept) begin
                    cmd_d   = req.req_cmd;
                    addr_d  = req.req_addr;
                    wdata_d = req.req_wdata;
                    state_d = (req.req_cmd == C1_NOP) ? ST_DONE : ST_A1;
                end
            end
            ST_A1:   state_d = ST_A2;
            ST_A2:   state_d = ST_TURN;
            ST_TURN: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the final timeout cycle still wins over the error.
                if (cmd_in == C1_WRITE32_RESP) begin
                    state_d = ST_DONE;
                    if (cmd_q == C1_READ8) begin
                        rdata_d = DW'(data_in[7:0]);
                    end else if (cmd_q == C1_READ16) begin
                        rdata_d = DW'(data_in);
                    end else if (cmd_q == C1_READ32) begin
                        lo_d    = data_in;
                        state_d = ST_R2;
                    end
                end else if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_R2: begin
                rdata_d = {data_in, lo_q};
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= C1_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule
